// File: rtl/eight_bit_pkg.sv
// Shared widths, segment constants, display payload and BCD-to-7-segment decode
// for the eight-bit bus/ALU/display path.
package eight_bit_pkg;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned SEG_W  = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'h40;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } conv_state_t;

    // Everything the scanned display shows: sign flag plus three BCD digits
    typedef struct packed {
        logic             sign;
        logic [BCD_W-1:0] bcd;
    } disp_t;

    // Segment order {g,f,e,d,c,b,a}, active high; non-decimal codes blank
    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [3:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble: one add-3/shift step per cycle over DATA_W cycles.
// A start pulse restarts the conversion from scratch at any time.
module bin_to_bcd
    import eight_bit_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [DATA_W-1:0] mag,
    output logic [BCD_W-1:0]  bcd,
    output logic              done_c
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] shift_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              run_q;
    logic [BCD_W-1:0]  adj_c;
    logic [BCD_W-1:0]  step_c;

    // Add 3 to every nibble >= 5, then shift in the next magnitude bit
    always_comb begin
        adj_c = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj_c[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        step_c = {adj_c[BCD_W-2:0], shift_q[DATA_W-1]};
    end

    // High during the cycle whose closing edge performs the final step
    assign done_c = run_q && (cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            shift_q <= '0;
            bcd     <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else if (start) begin
            shift_q <= mag;
            bcd     <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b1;
        end else if (run_q) begin
            shift_q <= {shift_q[DATA_W-2:0], 1'b0};
            bcd     <= step_c;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (done_c) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/output_display.sv
// Bus reader: captures a byte, converts it to sign + three decimal digits and
// scans them onto a 4-digit multiplexed 7-segment display.
module output_display
    import eight_bit_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [DATA_W-1:0] bus,
    input  logic              load,
    input  logic              signed_mode,
    output logic [DATA_W-1:0] value,
    output logic              busy,
    output logic [SEG_W-1:0]  seg,
    output logic [DIGITS-1:0] digit_sel
);

    localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    conv_state_t       state_q, state_d;
    disp_t             disp_q, disp_d;
    logic              sign_q;
    logic              neg_c;
    logic [DATA_W-1:0] mag_c;
    logic [BCD_W-1:0]  bcd;
    logic              done_c;
    logic              busy_d;

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [1:0]        idx_q, idx_d;
    logic              wrap_c;
    logic [SEG_W-1:0]  seg_d;
    logic [DIGITS-1:0] sel_d;

    // Two's-complement magnitude; 0x80 wraps to 128 which fits in 8 bits
    assign neg_c = signed_mode & bus[DATA_W-1];
    assign mag_c = neg_c ? DATA_W'(~bus + 8'd1) : bus;

    bin_to_bcd u_bin_to_bcd (
        .clk    (clk),
        .clr_n  (clr_n),
        .start  (load),
        .mag    (mag_c),
        .bcd    (bcd),
        .done_c (done_c)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            value  <= '0;
            sign_q <= 1'b0;
        end else if (load) begin
            value  <= bus;
            sign_q <= neg_c;
        end
    end

    // Conversion FSM; a new load always wins over an in-flight result
    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        case (state_q)
            ST_IDLE: begin
                if (load) state_d = ST_CONVERT;
            end
            ST_CONVERT: begin
                if (load)        state_d = ST_CONVERT;
                else if (done_c) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (load) begin
                    state_d = ST_CONVERT;
                end else begin
                    disp_d  = '{sign: sign_q, bcd: bcd};
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            disp_q  <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
            busy    <= busy_d;
        end
    end

    // Scan: seg is decoded from next-state values so it moves with digit_sel
    always_comb begin
        wrap_c = (pre_q == PRE_W'(CLK_DIV - 1));
        pre_d  = wrap_c ? '0 : pre_q + PRE_W'(1);
        idx_d  = wrap_c ? idx_q + 2'd1 : idx_q;
        sel_d  = DIGITS'(1) << idx_d;
        case (idx_d)
            2'd3:    seg_d = disp_d.sign ? SEG_MINUS : SEG_BLANK;
            2'd2:    seg_d = bcd_to_seg(disp_d.bcd[11:8]);
            2'd1:    seg_d = bcd_to_seg(disp_d.bcd[7:4]);
            default: seg_d = bcd_to_seg(disp_d.bcd[3:0]);
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pre_q     <= '0;
            idx_q     <= '0;
            seg       <= bcd_to_seg(4'd0);
            digit_sel <= DIGITS'(1);
        end else begin
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            seg       <= seg_d;
            digit_sel <= sel_d;
        end
    end

endmodule

// File: tb/tb_output_display.sv
// Self-checking bench for output_display: table vectors, random loads against a
// decimal reference model, and hand-written reload/reset sequences.
module tb_output_display;

    localparam int unsigned DIV = 4;

    logic       clk;
    logic       clr_n;
    logic [7:0] bus;
    logic       load;
    logic       signed_mode;
    logic [7:0] value;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] digit_sel;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc;
    logic [27:0] exp_disp;   // {sign, hundreds, tens, ones} segment patterns

    typedef struct {
        logic [7:0]  b;
        logic        sm;
        logic [27:0] segs;
    } vec_t;

    vec_t vecs [8];

    output_display #(.CLK_DIV(DIV)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .bus         (bus),
        .load        (load),
        .signed_mode (signed_mode),
        .value       (value),
        .busy        (busy),
        .seg         (seg),
        .digit_sel   (digit_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; expected scan index is (cyc / DIV) % 4
    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [27:0] model(input logic [7:0] b, input logic sm);
        logic [6:0] pat [10];
        int v;
        int mag;
        logic neg;
        pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        v = int'(b);
        if (sm && v >= 128) v = v - 256;
        neg = (v < 0);
        mag = neg ? -v : v;
        return {neg ? 7'h40 : 7'h00, pat[mag / 100], pat[(mag / 10) % 10], pat[mag % 10]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_scan();
        int idx;
        idx = (cyc / DIV) % 4;
        chk("digit_sel", 32'(digit_sel), 32'(4'b0001 << idx));
        chk("seg", 32'(seg), 32'(exp_disp[idx*7 +: 7]));
    endtask

    // One load pulse, then the full busy window and one complete scan of the result
    task automatic do_load(input logic [7:0] b, input logic sm, input logic [27:0] segs);
        bus = b;
        signed_mode = sm;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("value", 32'(value), 32'(b));
        chk("busy_start", 32'(busy), 32'd1);
        check_scan();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("busy_conv", 32'(busy), 32'd1);
            check_scan();
        end
        tick();
        exp_disp = segs;
        chk("busy_end", 32'(busy), 32'd0);
        check_scan();
        for (int i = 0; i < 4 * DIV; i++) begin
            tick();
            check_scan();
        end
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;

        clr_n = 1'b0;
        load = 1'b0;
        bus = 8'h00;
        signed_mode = 1'b0;
        exp_disp = {7'h00, 7'h3F, 7'h3F, 7'h3F};

        vecs[0] = '{8'hFF, 1'b0, {7'h00, 7'h5B, 7'h6D, 7'h6D}};
        vecs[1] = '{8'h80, 1'b1, {7'h40, 7'h06, 7'h5B, 7'h7F}};
        vecs[2] = '{8'h00, 1'b0, {7'h00, 7'h3F, 7'h3F, 7'h3F}};
        vecs[3] = '{8'h7F, 1'b1, {7'h00, 7'h06, 7'h5B, 7'h07}};
        vecs[4] = '{8'hFF, 1'b1, {7'h40, 7'h3F, 7'h3F, 7'h06}};
        vecs[5] = '{8'h9C, 1'b1, {7'h40, 7'h06, 7'h3F, 7'h3F}};
        vecs[6] = '{8'h9C, 1'b0, {7'h00, 7'h06, 7'h6D, 7'h7D}};
        vecs[7] = '{8'h0A, 1'b0, {7'h00, 7'h3F, 7'h06, 7'h3F}};

        // Reset held while load toggles
        for (int i = 0; i < 6; i++) begin
            bus = 8'hA5;
            load = i[0];
            tick();
            chk("rst_value", 32'(value), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            check_scan();
        end
        load = 1'b0;
        #2 clr_n = 1'b1;
        for (int i = 0; i < 4 * DIV + 2; i++) begin
            tick();
            chk("idle_busy", 32'(busy), 32'd0);
            check_scan();
        end

        for (int i = 0; i < 8; i++) begin
            do_load(vecs[i].b, vecs[i].sm, vecs[i].segs);
        end

        // Reload while busy: 0x2A is aborted three edges in, 0x07 wins
        bus = 8'h2A; signed_mode = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        check_scan();
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("busy_reload", 32'(busy), 32'd1);
            check_scan();
        end
        bus = 8'h07; load = 1'b1;
        tick();
        load = 1'b0;
        chk("value_reload", 32'(value), 32'h07);
        check_scan();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("busy_reload", 32'(busy), 32'd1);
            check_scan();
        end
        tick();
        exp_disp = {7'h00, 7'h3F, 7'h3F, 7'h07};
        chk("busy_reload_end", 32'(busy), 32'd0);
        check_scan();
        for (int i = 0; i < 4 * DIV; i++) begin
            tick();
            check_scan();
        end

        // Load held high for several edges: busy never drops, last byte wins
        load = 1'b1; signed_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus = 8'(8'hF0 + i);
            tick();
            chk("busy_held", 32'(busy), 32'd1);
            check_scan();
        end
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("busy_held_conv", 32'(busy), 32'd1);
            check_scan();
        end
        tick();
        exp_disp = model(8'hF4, 1'b1);
        chk("busy_held_end", 32'(busy), 32'd0);
        check_scan();

        // Random loads against the decimal model
        for (int i = 0; i < 24; i++) begin
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            do_load(rb, rs, model(rb, rs));
        end

        // Reset four edges into a conversion of 0x63
        bus = 8'h63; signed_mode = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        clr_n = 1'b0;
        #1;
        exp_disp = {7'h00, 7'h3F, 7'h3F, 7'h3F};
        chk("midrst_value", 32'(value), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        check_scan();
        #2 clr_n = 1'b1;
        for (int i = 0; i < 4 * DIV + 4; i++) begin
            tick();
            chk("midrst_busy_after", 32'(busy), 32'd0);
            check_scan();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
